reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Write-side initiator for the 8x8-bit register file: the producer that drives its write port.
- Merges writeback results from two sources, the ALU result path and the memory-load return path, into a single stream: wr_en, wr_sel, wr_data.
- Buffers ALU results that lose arbitration in a small FIFO.
- Maintains a per-register busy scoreboard so decode can detect pending writes before reading operands.

Parameters:
- DEPTH, 2, ALU holding-FIFO depth; legal values 2 or 3.
- STARVE_MAX, 4, maximum consecutive cycles a non-empty ALU FIFO may lose to loads before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle (valid & ready).
- alu_sel  in  3  ALU destination register.
- alu_data  in  8  ALU result.
- ld_valid  in  1  load-return result valid.
- ld_ready  out  1  load result accepted this cycle.
- ld_sel  in  3  load destination register.
- ld_data  in  8  load data.
- rsv_en  in  1  decode reserves a destination: set its busy bit.
- rsv_sel  in  3  register being reserved.
- chk_sel_0  in  3  operand-0 register to check.
- chk_sel_1  in  3  operand-1 register to check.
- chk_busy_0  out  1  busy_vec[chk_sel_0], combinational.
- chk_busy_1  out  1  busy_vec[chk_sel_1], combinational.
- wr_en  out  1  register-file write enable, registered.
- wr_sel  out  3  register-file write select, registered.
- wr_data  out  8  register-file write data, registered.
- busy_vec  out  8  scoreboard; bit n = write to register n pending.
- fifo_level  out  2  ALU FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - wr_en=0, wr_sel=0, wr_data=0.
  - busy_vec=0, FIFO flushed (fifo_level=0), starvation counter=0.
  - Buffered data is discarded.
- Handshakes:
  - alu_ready = (fifo_level < DEPTH).
  - ld_ready = ~force, where force = (fifo_level != 0) & (starve_cnt == STARVE_MAX).
  - Both ready outputs are combinational from state only; they never depend on the valid inputs.
- Per-cycle winner selection, in priority order:
  1. If force: FIFO head wins; the load is stalled.
  2. Else if ld_valid: load wins.
  3. Else if FIFO non-empty: FIFO head wins.
  4. Else if alu_valid & alu_ready: bypass, the incoming ALU result wins directly.
  5. Else: no write.
- Write output:
  - The winner is registered: wr_en/wr_sel/wr_data update at the next edge.
  - Latency input-to-wr_en is 1 cycle for loads and for the bypass path.
- FIFO rules:
  - An accepted ALU result that is not the bypass winner is pushed to the FIFO tail.
  - A push and a pop in the same cycle leave the level unchanged; a push when full is impossible because alu_ready=0.
  - Entries drain in FIFO order; no reordering.
  - Pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments when the load wins and the FIFO is non-empty.
  - Clears to 0 when the FIFO head wins or the FIFO is empty.
  - Saturates at STARVE_MAX.
- Scoreboard:
  - On each edge, clear the bit of the winner's destination (the write issued at that edge), then set bit rsv_sel if rsv_en.
  - Set wins over clear on the same register in the same cycle.
  - A write to a non-reserved register is legal; its busy bit stays 0.
  - Once wr_en is high for register n, busy bit n is already 0. The register file's same-cycle write-to-read forwarding covers that cycle.
- Simultaneous load and ALU to the same register:
  - The load is written first; the ALU value follows on a later cycle.
  - The later ALU write is the final value.

Test Plan:
- Reset, then single ALU result sel=3, data=0x5A with FIFO empty and ld_valid=0 -> next cycle wr_en=1, wr_sel=3, wr_data=0x5A; fifo_level stays 0.
- rsv_en with rsv_sel=5, then ld_valid with sel=5, data=0x11 two cycles later -> busy_vec=0x20 until the write edge, then 0x00 coincident with wr_en=1, wr_data=0x11; chk_sel_0=5 reads chk_busy_0=1 then 0.
- Same cycle: ld (sel=1, 0xAA) and alu (sel=2, 0xBB) -> write reg1=0xAA, then reg2=0xBB on the following cycle; fifo_level 1 then 0.
- Hold ld_valid=1 continuously while pushing 3 ALU results (DEPTH=2) -> alu_ready=0 once fifo_level=2. After STARVE_MAX=4 load wins, ld_ready=0 for one cycle and the FIFO head is written; counter returns to 0.
- rsv_en for sel=4 in the same cycle the FIFO head for reg4 wins -> busy_vec[4]=1 after the edge (set wins).
- Assert reset mid-stream with fifo_level=2 and busy_vec=0xFF -> asynchronously wr_en=0, busy_vec=0, fifo_level=0. After release, no stale writes appear.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-side arbiter: merges load returns and ALU results into one write stream,
// buffers losing ALU results, and keeps a per-register pending-write scoreboard.
module reg_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [2:0] alu_sel,
  input  logic [7:0] alu_data,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [2:0] ld_sel,
  input  logic [7:0] ld_data,
  input  logic       rsv_en,
  input  logic [2:0] rsv_sel,
  input  logic [2:0] chk_sel_0,
  input  logic [2:0] chk_sel_1,
  output logic       chk_busy_0,
  output logic       chk_busy_1,
  output logic       wr_en,
  output logic [2:0] wr_sel,
  output logic [7:0] wr_data,
  output logic [7:0] busy_vec,
  output logic [1:0] fifo_level
);

  localparam logic [1:0] LastPtr   = 2'(DEPTH - 1);
  localparam logic [1:0] DepthLvl  = 2'(DEPTH);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {SrcNone, SrcLoad, SrcFifo, SrcBypass} src_e;

  // Storage sized for the largest legal DEPTH; only DEPTH entries are ever addressed.
  logic [10:0] mem_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, level_q, level_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_sel_q, wr_sel_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        force_head, alu_accept, push, pop;
  logic [10:0] win;
  src_e        src;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    force_head = (level_q != 2'd0) && (starve_q == StarveMax);
    alu_ready  = level_q < DepthLvl;
    ld_ready   = ~force_head;
    alu_accept = alu_valid & alu_ready;

    if (force_head)             src = SrcFifo;
    else if (ld_valid)          src = SrcLoad;
    else if (level_q != 2'd0)   src = SrcFifo;
    else if (alu_accept)        src = SrcBypass;
    else                        src = SrcNone;

    case (src)
      SrcLoad:   win = {ld_sel, ld_data};
      SrcFifo:   win = mem_q[rd_ptr_q];
      SrcBypass: win = {alu_sel, alu_data};
      default:   win = '0;
    endcase

    pop      = (src == SrcFifo);
    push     = alu_accept & (src != SrcBypass);
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    level_d  = level_q + {1'b0, push} - {1'b0, pop};

    // Only loads that overtake a waiting ALU result count toward starvation.
    if ((src == SrcLoad) && (level_q != 2'd0)) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end

    wr_en_d   = (src != SrcNone);
    wr_sel_d  = wr_en_d ? win[10:8] : wr_sel_q;
    wr_data_d = wr_en_d ? win[7:0]  : wr_data_q;

    // Reservation is applied after the clear so a same-cycle set wins.
    busy_d = busy_q;
    if (wr_en_d) busy_d[win[10:8]] = 1'b0;
    if (rsv_en)  busy_d[rsv_sel]   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      level_q   <= 2'd0;
      starve_q  <= 4'd0;
      busy_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 3'd0;
      wr_data_q <= 8'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {alu_sel, alu_data};
  end

  assign chk_busy_0 = busy_q[chk_sel_0];
  assign chk_busy_1 = busy_q[chk_sel_1];
  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_data    = wr_data_q;
  assign busy_vec   = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_reg_wb_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic       clk, reset;
  logic       alu_valid, alu_ready, ld_valid, ld_ready, rsv_en;
  logic [2:0] alu_sel, ld_sel, rsv_sel, chk_sel_0, chk_sel_1, wr_sel;
  logic [7:0] alu_data, ld_data, wr_data, busy_vec;
  logic       chk_busy_0, chk_busy_1, wr_en;
  logic [1:0] fifo_level;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .chk_sel_0(chk_sel_0), .chk_sel_1(chk_sel_1),
    .chk_busy_0(chk_busy_0), .chk_busy_1(chk_busy_1),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy_vec(busy_vec), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue of {sel,data}, registers as plain variables.
  logic [10:0] q[$];
  int          m_starve;
  logic [7:0]  m_busy;
  logic        m_wr_en;
  logic [2:0]  m_wr_sel;
  logic [7:0]  m_wr_data;
  int          m_n;
  logic        m_frc, m_acc, m_any, m_ld_won, m_bypass;
  logic [10:0] m_w;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_starve  = 0;
      m_busy    = 8'h00;
      m_wr_en   = 1'b0;
      m_wr_sel  = 3'd0;
      m_wr_data = 8'h00;
    end else begin
      m_n      = q.size();
      m_frc    = (m_n != 0) && (m_starve == STARVE_MAX);
      m_acc    = alu_valid && (m_n < DEPTH);
      m_any    = 1'b1;
      m_ld_won = 1'b0;
      m_bypass = 1'b0;
      m_w      = '0;
      if (m_frc) m_w = q.pop_front();
      else if (ld_valid) begin
        m_w = {ld_sel, ld_data};
        m_ld_won = 1'b1;
      end else if (m_n != 0) m_w = q.pop_front();
      else if (m_acc) begin
        m_w = {alu_sel, alu_data};
        m_bypass = 1'b1;
      end else m_any = 1'b0;
      if (m_acc && !m_bypass) q.push_back({alu_sel, alu_data});
      if (m_ld_won && m_n != 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else m_starve = 0;
      m_wr_en = m_any;
      if (m_any) begin
        m_wr_sel  = m_w[10:8];
        m_wr_data = m_w[7:0];
        m_busy[m_w[10:8]] = 1'b0;
      end
      if (rsv_en) m_busy[rsv_sel] = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("wr_en", int'(wr_en), int'(m_wr_en));
      if (m_wr_en) begin
        check("wr_sel", int'(wr_sel), int'(m_wr_sel));
        check("wr_data", int'(wr_data), int'(m_wr_data));
      end
      check("busy_vec", int'(busy_vec), int'(m_busy));
      check("fifo_level", int'(fifo_level), q.size());
      check("alu_ready", int'(alu_ready), int'(q.size() < DEPTH));
      check("ld_ready", int'(ld_ready), int'(!(q.size() != 0 && m_starve == STARVE_MAX)));
      check("chk_busy_0", int'(chk_busy_0), int'(m_busy[chk_sel_0]));
      check("chk_busy_1", int'(chk_busy_1), int'(m_busy[chk_sel_1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_sel = 0; alu_data = 0;
    ld_valid = 0; ld_sel = 0; ld_data = 0;
    rsv_en = 0; rsv_sel = 0; chk_sel_0 = 0; chk_sel_1 = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1'b1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_sel", int'(wr_sel), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy_vec), 0);
    check("rst_level", int'(fifo_level), 0);
    reset = 1'b0;

    // Bypass: single ALU result with empty FIFO
    alu_valid = 1; alu_sel = 3; alu_data = 8'h5A;
    step();
    alu_valid = 0;
    check("byp_wr_en", int'(wr_en), 1);
    check("byp_wr_sel", int'(wr_sel), 3);
    check("byp_wr_data", int'(wr_data), 8'h5A);
    check("byp_level", int'(fifo_level), 0);

    // Reserve reg5, load into it two cycles later
    rsv_en = 1; rsv_sel = 5; chk_sel_0 = 5;
    step();
    rsv_en = 0;
    check("rsv_busy", int'(busy_vec), 8'h20);
    check("rsv_chk0", int'(chk_busy_0), 1);
    step();
    check("rsv_busy_hold", int'(busy_vec), 8'h20);
    ld_valid = 1; ld_sel = 5; ld_data = 8'h11;
    step();
    ld_valid = 0;
    check("ld5_wr_data", int'(wr_data), 8'h11);
    check("ld5_busy", int'(busy_vec), 8'h00);
    #1 check("ld5_chk0", int'(chk_busy_0), 0);

    // Simultaneous load and ALU
    ld_valid = 1; ld_sel = 1; ld_data = 8'hAA;
    alu_valid = 1; alu_sel = 2; alu_data = 8'hBB;
    step();
    ld_valid = 0; alu_valid = 0;
    check("sim_wr_sel_a", int'(wr_sel), 1);
    check("sim_wr_data_a", int'(wr_data), 8'hAA);
    check("sim_level_a", int'(fifo_level), 1);
    step();
    check("sim_wr_sel_b", int'(wr_sel), 2);
    check("sim_wr_data_b", int'(wr_data), 8'hBB);
    check("sim_level_b", int'(fifo_level), 0);

    // Starvation: loads held while ALU results queue up
    ld_valid = 1; ld_sel = 6; ld_data = 8'h60;
    alu_valid = 1; alu_sel = 0; alu_data = 8'hC0;
    step();
    alu_sel = 1; alu_data = 8'hC1;
    step();
    check("stv_level_full", int'(fifo_level), 2);
    check("stv_alu_ready", int'(alu_ready), 0);
    alu_sel = 2; alu_data = 8'hC2;
    repeat (3) step();
    check("stv_ld_ready_lo", int'(ld_ready), 0);
    check("stv_ld_write", int'(wr_sel), 6);
    step();
    check("stv_head_sel", int'(wr_sel), 0);
    check("stv_head_data", int'(wr_data), 8'hC0);
    check("stv_ld_ready_hi", int'(ld_ready), 1);
    check("stv_level", int'(fifo_level), 1);
    ld_valid = 0; alu_valid = 0;
    step();
    check("stv_drain_data", int'(wr_data), 8'hC1);
    check("stv_drain_level", int'(fifo_level), 0);

    // Reservation coinciding with FIFO head write to the same register
    ld_valid = 1; ld_sel = 1; ld_data = 8'h01;
    alu_valid = 1; alu_sel = 4; alu_data = 8'h44;
    step();
    ld_valid = 0; alu_valid = 0;
    check("sw_level", int'(fifo_level), 1);
    rsv_en = 1; rsv_sel = 4;
    step();
    rsv_en = 0;
    check("sw_wr_sel", int'(wr_sel), 4);
    check("sw_wr_data", int'(wr_data), 8'h44);
    check("sw_busy4", int'(busy_vec[4]), 1);

    // Mid-stream asynchronous reset with full FIFO and all registers busy
    for (int i = 0; i < 7; i++) begin
      rsv_en = 1; rsv_sel = 3'(i);
      step();
    end
    ld_valid = 1; ld_sel = 7; ld_data = 8'h77;
    alu_valid = 1; alu_sel = 2; alu_data = 8'hD0; rsv_sel = 7;
    step();
    alu_data = 8'hD1;
    step();
    ld_valid = 0; alu_valid = 0; rsv_en = 0;
    check("mr_busy_ff", int'(busy_vec), 8'hFF);
    check("mr_level2", int'(fifo_level), 2);
    #1 reset = 1'b1;
    #1;
    check("mr_wr_en", int'(wr_en), 0);
    check("mr_busy", int'(busy_vec), 0);
    check("mr_level", int'(fifo_level), 0);
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    check("mr_no_stale", int'(wr_en), 0);

    // Randomized traffic; load pressure varies by block
    for (int c = 0; c < 4000; c++) begin
      int ld_pct;
      ld_pct = ((c / 500) % 3 == 0) ? 90 : (((c / 500) % 3 == 1) ? 50 : 15);
      ld_valid  = ($urandom_range(0, 99) < ld_pct);
      ld_sel    = 3'($urandom);
      ld_data   = 8'($urandom);
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_sel   = 3'($urandom);
      alu_data  = 8'($urandom);
      rsv_en    = ($urandom_range(0, 99) < 40);
      rsv_sel   = 3'($urandom);
      chk_sel_0 = 3'($urandom);
      chk_sel_1 = 3'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
